// File: rtl/bullet_fire_scheduler.sv
// ============================================================================
// bullet_fire_scheduler : arms the lowest free bullet slot on a fire press,
// applies a frame-counted cooldown and retires slots at the top row.
// Optional macro FIRE_AUTO_REPEAT_EN: a held button keeps firing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bullet_fire_scheduler #(
  parameter int N_BULLETS       = 4,
  parameter int Y_W             = 10,
  parameter int Y_TOP           = 66,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     pbG,
  input  logic [N_BULLETS*Y_W-1:0] bulletPosY,
  output logic [N_BULLETS-1:0]     enb,
  output logic [N_BULLETS-1:0]     fire_pulse,
  output logic                     cooldown_busy
);

  typedef enum logic [0:0] {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_BULLETS-1:0] enb_q, enb_d;
  logic [N_BULLETS-1:0] fire_q, fire_d;
  logic                 sync1_q, sync2_q, prev_btn_q;

  logic                 btn_s;
  logic                 press;
  logic                 trigger;
  logic [N_BULLETS-1:0] free_vec;
  logic [N_BULLETS-1:0] spawn_onehot;

  assign btn_s = sync2_q;
  assign press = prev_btn_q & ~btn_s;

`ifdef FIRE_AUTO_REPEAT_EN
  assign trigger = press | ~btn_s;
`else
  assign trigger = press;
`endif

  // Isolate the lowest zero of the registered enable vector.
  assign free_vec     = ~enb_q;
  assign spawn_onehot = free_vec & (~free_vec + N_BULLETS'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enb_d   = enb_q;
    fire_d  = '0;

    for (int i = 0; i < N_BULLETS; i++) begin
      if (enb_q[i] && (bulletPosY[i*Y_W +: Y_W] == Y_W'(Y_TOP))) begin
        enb_d[i] = 1'b0;
      end
    end

    case (state_q)
      READY: begin
        if (trigger && (|free_vec)) begin
          enb_d  = enb_d | spawn_onehot;
          fire_d = spawn_onehot;
          if (COOLDOWN_FRAMES != 0) begin
            cnt_d   = CNT_W'(COOLDOWN_FRAMES);
            state_d = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = READY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = READY;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      cnt_q      <= '0;
      enb_q      <= '0;
      fire_q     <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_btn_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enb_q      <= enb_d;
      fire_q     <= fire_d;
      sync1_q    <= pbG;
      sync2_q    <= sync1_q;
      prev_btn_q <= sync2_q;
    end
  end

  assign enb           = enb_q;
  assign fire_pulse    = fire_q;
  assign cooldown_busy = (state_q == COOLDOWN);

endmodule

`default_nettype wire

// File: tb/tb_bullet_fire_scheduler.sv
// ============================================================================
// tb_bullet_fire_scheduler : directed self-checking bench for the scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bullet_fire_scheduler;

  localparam int N  = 4;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0;
  logic          pbG = 1'b1;
  logic [N*YW-1:0] bulletPosY = '0;
  logic [N-1:0]  enb;
  logic [N-1:0]  fire_pulse;
  logic          cooldown_busy;

  int n_checks = 0;
  int n_errors = 0;

  bullet_fire_scheduler #(
    .N_BULLETS(N), .Y_W(YW), .Y_TOP(66), .COOLDOWN_FRAMES(8), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pbG(pbG),
    .bulletPosY(bulletPosY), .enb(enb), .fire_pulse(fire_pulse),
    .cooldown_busy(cooldown_busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
    end
  endtask

  // Press; after return the shot edge (t+2) has just passed.
  task automatic press_hold();
    pbG = 1'b0;
    step(3);
  endtask

  task automatic release_btn();
    pbG = 1'b1;
    step(3);
  endtask

  task automatic set_pos(input int slot, input int val);
    bulletPosY[slot*YW +: YW] = YW'(val);
  endtask

  logic [N-1:0] acc_enb, acc_fire;
  int shots;
  int ticks_seen;
  int shot_tick [0:7];
  logic [N-1:0] shot_slot [0:7];

  initial begin
    // T1: reset and quiet period
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check_value("rst_enb", 32'(enb), 32'h0);
    check_value("rst_fire", 32'(fire_pulse), 32'h0);
    check_value("rst_busy", 32'(cooldown_busy), 32'h0);
    acc_enb = '0; acc_fire = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      acc_enb  |= enb;
      acc_fire |= fire_pulse;
    end
    check_value("quiet_enb", 32'(acc_enb), 32'h0);
    check_value("quiet_fire", 32'(acc_fire), 32'h0);

    // T2: single shot with latency boundary
    pbG = 1'b0;
    step(2);
    check_value("lat_t1_enb", 32'(enb), 32'h0);
    step(1);
    check_value("shot0_enb", 32'(enb), 32'h1);
    check_value("shot0_fire", 32'(fire_pulse), 32'h1);
    check_value("shot0_busy", 32'(cooldown_busy), 32'h1);
    step(1);
    check_value("shot0_fire_off", 32'(fire_pulse), 32'h0);
    release_btn();

    // T3: press during cooldown is discarded
    tick_n(3);
    pbG = 1'b0;
    step(4);
    check_value("cd_reject_enb", 32'(enb), 32'h1);
    release_btn();
    tick_n(4);
    check_value("cd_busy_7", 32'(cooldown_busy), 32'h1);
    tick_n(1);
    check_value("cd_busy_8", 32'(cooldown_busy), 32'h0);
    press_hold();
    check_value("shot1_enb", 32'(enb), 32'h3);
    release_btn();
    tick_n(8);

    // T4: fill, full-discard, retire, reuse
    press_hold();
    check_value("shot2_enb", 32'(enb), 32'h7);
    release_btn();
    tick_n(8);
    press_hold();
    check_value("shot3_enb", 32'(enb), 32'hF);
    release_btn();
    tick_n(8);
    pbG = 1'b0;
    acc_fire = '0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      acc_fire |= fire_pulse;
    end
    check_value("full_enb", 32'(enb), 32'hF);
    check_value("full_fire", 32'(acc_fire), 32'h0);
    check_value("full_busy", 32'(cooldown_busy), 32'h0);
    release_btn();
    set_pos(2, 66);
    step(1);
    check_value("retire2_enb", 32'(enb), 32'hB);
    set_pos(2, 0);
    press_hold();
    check_value("reuse2_enb", 32'(enb), 32'hF);
    check_value("reuse2_fire", 32'(fire_pulse), 32'h4);
    release_btn();
    tick_n(8);

    // T5: retire slot0 on the same edge as a spawn into slot3
    set_pos(3, 66);
    step(1);
    set_pos(3, 0);
    check_value("retire3_enb", 32'(enb), 32'h7);
    pbG = 1'b0;
    step(2);
    set_pos(0, 66);
    step(1);
    set_pos(0, 0);
    check_value("same_edge_enb", 32'(enb), 32'hE);
    check_value("same_edge_fire", 32'(fire_pulse), 32'h8);
    release_btn();
    tick_n(8);

    // Reset mid-cooldown
    press_hold();
    check_value("refill0_enb", 32'(enb), 32'hF);
    release_btn();
    tick_n(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    check_value("midrst_enb", 32'(enb), 32'h0);
    check_value("midrst_busy", 32'(cooldown_busy), 32'h0);
    press_hold();
    check_value("post_rst_enb", 32'(enb), 32'h1);
    release_btn();

    // T6: held button over 40 frame ticks
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    shots = 0;
    ticks_seen = 0;
    pbG = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (fire_pulse != '0 && shots < 8) begin
        shot_tick[shots] = ticks_seen; shot_slot[shots] = fire_pulse; shots++;
      end
    end
    for (int k = 0; k < 40; k++) begin
      frame_tick = 1'b1;
      step(1);
      ticks_seen++;
      frame_tick = 1'b0;
      if (fire_pulse != '0 && shots < 8) begin
        shot_tick[shots] = ticks_seen; shot_slot[shots] = fire_pulse; shots++;
      end
      step(1);
      if (fire_pulse != '0 && shots < 8) begin
        shot_tick[shots] = ticks_seen; shot_slot[shots] = fire_pulse; shots++;
      end
    end
    pbG = 1'b1;
`ifdef FIRE_AUTO_REPEAT_EN
    check_value("hold_shots", 32'(shots), 32'd4);
    for (int s = 0; s < 4; s++) begin
      if (s < shots) begin
        check_value("hold_slot", 32'(shot_slot[s]), 32'(1 << s));
        check_value("hold_tick", 32'(shot_tick[s]), 32'(8 * s));
      end
    end
    check_value("hold_enb", 32'(enb), 32'hF);
`else
    check_value("hold_shots", 32'(shots), 32'd1);
    if (shots > 0) check_value("hold_slot", 32'(shot_slot[0]), 32'h1);
    check_value("hold_enb", 32'(enb), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
